// File: rtl/effects_delay_line.sv
// rtl/effects_delay_line.sv - circular sample buffer producing echo and flanger output pairs
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   sample_in      8-bit input audio sample
//   sample_stb     one-cycle strobe, sample_in valid (ignored while busy)
//   realt_echo     realtime sample, echo pair
//   delay1_echo    sample from ECHO_DELAY samples earlier (0 until buffer holds that many)
//   realt_flanger  realtime sample, flanger pair
//   delay1_flanger sample from flange_delay samples earlier (0 until buffer holds that many)
//   sample_valid   one-cycle pulse, all four outputs updated
//   busy           high while a sample is being processed

module effects_delay_line #(
    parameter int ADDR_W     = 10,
    parameter int ECHO_DELAY = 800,
    parameter int FLANGE_MIN = 16,
    parameter int FLANGE_MAX = 256,
    parameter int LFO_DIV    = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sample_in,
    input  logic       sample_stb,
    output logic [7:0] realt_echo,
    output logic [7:0] delay1_echo,
    output logic [7:0] realt_flanger,
    output logic [7:0] delay1_flanger,
    output logic       sample_valid,
    output logic       busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LFO_W = (LFO_DIV > 1) ? $clog2(LFO_DIV) : 1;

    localparam logic [ADDR_W-1:0] ECHO_D   = ADDR_W'(ECHO_DELAY);
    localparam logic [ADDR_W-1:0] FMIN     = ADDR_W'(FLANGE_MIN);
    localparam logic [ADDR_W-1:0] FMAX     = ADDR_W'(FLANGE_MAX);
    localparam logic [ADDR_W-1:0] FILL_MAX = '1;
    localparam logic [LFO_W-1:0]  LFO_LAST = LFO_W'(LFO_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_ECHO,
        RD_FLANGE,
        LATCH
    } state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] flange_delay;
    logic [ADDR_W-1:0] flange_step;
    logic [LFO_W-1:0]  lfo_cnt;
    logic              lfo_up;
    logic [7:0]        in_reg;
    logic [7:0]        echo_data;

    assign wr_en = (state == IDLE) && sample_stb && !reset;

    // The read address is only meaningful in RD_ECHO and RD_FLANGE; the
    // pointer subtraction wraps naturally over the ADDR_W-bit buffer.
    always_comb begin
        rd_addr = wr_ptr - flange_delay;
        if (state == RD_ECHO) begin
            rd_addr = wr_ptr - ECHO_D;
        end
    end

    always_comb begin
        flange_step = lfo_up ? flange_delay + ADDR_W'(1) : flange_delay - ADDR_W'(1);
    end

    // Buffer: one write port, registered read port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sample_in;
        end
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            fill_cnt       <= '0;
            flange_delay   <= FMIN;
            lfo_cnt        <= '0;
            lfo_up         <= 1'b1;
            in_reg         <= '0;
            echo_data      <= '0;
            realt_echo     <= '0;
            delay1_echo    <= '0;
            realt_flanger  <= '0;
            delay1_flanger <= '0;
            sample_valid   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_stb) begin
                        in_reg <= sample_in;
                        busy   <= 1'b1;
                        state  <= RD_ECHO;
                    end
                end
                RD_ECHO: begin
                    state <= RD_FLANGE;
                end
                RD_FLANGE: begin
                    // fill_cnt counts samples stored before this one, so a
                    // delay is only backed by real data once fill_cnt reaches it.
                    echo_data <= (fill_cnt >= ECHO_D) ? rd_data : 8'h00;
                    state     <= LATCH;
                end
                LATCH: begin
                    realt_echo     <= in_reg;
                    realt_flanger  <= in_reg;
                    delay1_echo    <= echo_data;
                    delay1_flanger <= (fill_cnt >= flange_delay) ? rd_data : 8'h00;
                    sample_valid   <= 1'b1;
                    busy           <= 1'b0;
                    wr_ptr         <= wr_ptr + ADDR_W'(1);
                    if (fill_cnt != FILL_MAX) begin
                        fill_cnt <= fill_cnt + ADDR_W'(1);
                    end
                    // Triangle LFO: dwell LFO_DIV samples per value, turning
                    // around as soon as an endpoint is reached.
                    if (lfo_cnt == LFO_LAST) begin
                        lfo_cnt      <= '0;
                        flange_delay <= flange_step;
                        if (lfo_up && flange_step == FMAX) begin
                            lfo_up <= 1'b0;
                        end else if (!lfo_up && flange_step == FMIN) begin
                            lfo_up <= 1'b1;
                        end
                    end else begin
                        lfo_cnt <= lfo_cnt + LFO_W'(1);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_effects_delay_line.sv
// tb/tb_effects_delay_line.sv - directed self-checking bench for effects_delay_line

module tb_effects_delay_line;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sample_in = '0;
    logic       sample_stb = 1'b0;

    logic [7:0] d_re, d_de, d_rf, d_df;
    logic       d_valid, d_busy;
    logic [7:0] a_re, a_de, a_rf, a_df;
    logic       a_valid, a_busy;
    logic [7:0] b_re, b_de, b_rf, b_df;
    logic       b_valid, b_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    effects_delay_line u_dflt (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_stb(sample_stb),
        .realt_echo(d_re), .delay1_echo(d_de), .realt_flanger(d_rf), .delay1_flanger(d_df),
        .sample_valid(d_valid), .busy(d_busy)
    );

    effects_delay_line #(
        .ADDR_W(10), .ECHO_DELAY(4), .FLANGE_MIN(2), .FLANGE_MAX(3), .LFO_DIV(1000)
    ) u_a (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_stb(sample_stb),
        .realt_echo(a_re), .delay1_echo(a_de), .realt_flanger(a_rf), .delay1_flanger(a_df),
        .sample_valid(a_valid), .busy(a_busy)
    );

    effects_delay_line #(
        .ADDR_W(3), .ECHO_DELAY(5), .FLANGE_MIN(2), .FLANGE_MAX(4), .LFO_DIV(2)
    ) u_b (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_stb(sample_stb),
        .realt_echo(b_re), .delay1_echo(b_de), .realt_flanger(b_rf), .delay1_flanger(b_df),
        .sample_valid(b_valid), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_stb = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Strobe one sample, then advance to the cycle where sample_valid must be high.
    task automatic send(input logic [7:0] v);
        sample_in = v;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        repeat (3) tick();
        vectors++;
        if (d_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL send_valid sample=%02h got=%b want=1", v, d_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({d_re, d_de, d_rf, d_df} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%08h want=00000000", {d_re, d_de, d_rf, d_df});
        end
        vectors++;
        if ({d_valid, d_busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_valid_busy got=%b want=00", {d_valid, d_busy});
        end
    endtask

    task automatic test_single();
        do_reset();
        sample_in = 8'h5A;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            vectors++;
            if ({d_busy, d_valid} !== 2'b10) begin
                miscompares++;
                $display("FAIL single_busy cycle=%0d got=%b want=10", c, {d_busy, d_valid});
            end
            tick();
        end
        vectors++;
        if ({d_busy, d_valid} !== 2'b01) begin
            miscompares++;
            $display("FAIL single_valid got=%b want=01", {d_busy, d_valid});
        end
        vectors++;
        if ({d_re, d_rf, d_de, d_df} !== 32'h5A5A0000) begin
            miscompares++;
            $display("FAIL single_outputs got=%08h want=5a5a0000", {d_re, d_rf, d_de, d_df});
        end
        tick();
        vectors++;
        if ({d_valid, d_re, d_rf} !== 17'h05A5A) begin
            miscompares++;
            $display("FAIL single_hold got=%05h want=05a5a", {d_valid, d_re, d_rf});
        end
    endtask

    // ECHO_DELAY=4, flanger fixed at 2 (LFO_DIV far larger than the run).
    task automatic test_fill();
        logic [7:0] exp_e, exp_f;
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            send(8'(n));
            exp_e = (n > 4) ? 8'(n - 4) : 8'h00;
            exp_f = (n > 2) ? 8'(n - 2) : 8'h00;
            vectors++;
            if ({a_re, a_rf, a_de, a_df} !== {8'(n), 8'(n), exp_e, exp_f}) begin
                miscompares++;
                $display("FAIL fill n=%0d got=%08h want=%08h", n,
                         {a_re, a_rf, a_de, a_df}, {8'(n), 8'(n), exp_e, exp_f});
            end
            repeat (4) tick();
        end
    endtask

    // 8-entry buffer wrap with ECHO_DELAY=5, plus triangle LFO 2..4 stepping every 2 samples.
    task automatic test_wrap_lfo();
        int sched [8] = '{2, 2, 3, 3, 4, 4, 3, 3};
        int fd;
        logic [7:0] exp_e, exp_f, exp_df;
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            send(8'(n));
            fd = sched[(n - 1) % 8];
            exp_e = (n >= 6) ? 8'(n - 5) : 8'h00;
            exp_f = (n - 1 >= fd) ? 8'(n - fd) : 8'h00;
            vectors++;
            if ({b_re, b_de, b_df} !== {8'(n), exp_e, exp_f}) begin
                miscompares++;
                $display("FAIL wrap_lfo n=%0d delay=%0d got=%06h want=%06h", n, fd,
                         {b_re, b_de, b_df}, {8'(n), exp_e, exp_f});
            end
            exp_df = (n > 16) ? 8'(n - 16) : 8'h00;
            vectors++;
            if ({d_de, d_df} !== {8'h00, exp_df}) begin
                miscompares++;
                $display("FAIL default_fill n=%0d got=%04h want=%04h", n, {d_de, d_df}, {8'h00, exp_df});
            end
            repeat (2) tick();
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        logic exp_v;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            sample_in = 8'(8'h10 + c);
            sample_stb = (c == 0 || c == 1 || c == 3 || c == 4);
            tick();
            exp_v = (c == 3 || c == 7);
            if (d_valid === 1'b1) pulses++;
            vectors++;
            if (d_valid !== exp_v) begin
                miscompares++;
                $display("FAIL b2b_valid cycle=%0d got=%b want=%b", c + 1, d_valid, exp_v);
            end
            if (c == 3 || c == 7) begin
                vectors++;
                if (d_re !== ((c == 3) ? 8'h10 : 8'h14)) begin
                    miscompares++;
                    $display("FAIL b2b_sample cycle=%0d got=%02h want=%02h", c + 1, d_re,
                             (c == 3) ? 8'h10 : 8'h14);
                end
            end
        end
        sample_stb = 1'b0;
        vectors++;
        if (pulses != 2) begin
            miscompares++;
            $display("FAIL b2b_pulses got=%0d want=2", pulses);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h80 + i));
            repeat (2) tick();
        end
        sample_in = 8'h44;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({b_re, b_de, b_rf, b_df, b_busy} !== 33'h0) begin
            miscompares++;
            $display("FAIL midop_clear got=%09h want=000000000", {b_re, b_de, b_rf, b_df, b_busy});
        end
        for (int c = 0; c < 6; c++) begin
            vectors++;
            if (b_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midop_no_valid cycle=%0d got=%b want=0", c, b_valid);
            end
            tick();
        end
        send(8'h33);
        vectors++;
        if ({b_re, b_rf, b_de, b_df} !== 32'h33330000) begin
            miscompares++;
            $display("FAIL midop_restart got=%08h want=33330000", {b_re, b_rf, b_de, b_df});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap_lfo();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
